pixel_window_shifter: RTL

- Parametrised sliding-window generator for streamed pixel lines.
- Accepts one pixel per handshake and presents a TAPS-wide horizontal window centred on each pixel of the line, with the newest pixel in the MSB slot.
- Pads line edges so each line of LINE_W input pixels yields exactly LINE_W windows.
- Sits between the pixel source and the horizontal convolution/filter stages.

---
 rtl/pixel_window_pkg.sv | 15 +
 rtl/window_shift_reg.sv | 34 +++
 rtl/pixel_window_shifter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pixel_window_pkg.sv
// Shared types and helpers for the pixel window shifter.
package pixel_window_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  // Counter width that stays >= 1 bit for tiny ranges.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/window_shift_reg.sv
// TAPS-slot pixel window register: load-fill, shift-in from the MSB side, or hold.
module window_shift_reg
  import pixel_window_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned TAPS   = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_load,
  input  logic                     i_shift,
  input  logic [DATA_W-1:0]        i_din,
  input  logic [DATA_W-1:0]        i_fill,
  output logic [TAPS*DATA_W-1:0]   o_window
);

  localparam int unsigned WIN_W = TAPS * DATA_W;

  logic [WIN_W-1:0] r_window;

  // Newest pixel enters slot TAPS-1; slot 0 drops out on a shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_window <= '0;
    end else if (i_load) begin
      r_window <= {i_din, {(TAPS-1){i_fill}}};
    end else if (i_shift) begin
      r_window <= {i_din, r_window[WIN_W-1:DATA_W]};
    end
  end

  assign o_window = r_window;

endmodule

// File: rtl/pixel_window_shifter.sv
// Sliding horizontal window generator with edge padding per line.
// Define PIXEL_WINDOW_REPLICATE_EN for edge-replication padding (default pads with zero).
module pixel_window_shifter
  import pixel_window_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned TAPS   = 5,
  parameter int unsigned LINE_W = 640
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             in_pixel,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [TAPS*DATA_W-1:0]        out_window,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [cnt_w(LINE_W)-1:0]      out_x,
  output logic                          out_eol
);

  localparam int unsigned H   = (TAPS - 1) / 2;
  localparam int unsigned X_W = cnt_w(LINE_W);
  localparam int unsigned F_W = cnt_w(H);

  state_t             r_state, w_state_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_eol, w_eol_nxt;
  logic [X_W-1:0]     r_x, w_x_nxt;
  logic [X_W-1:0]     r_in_cnt, w_in_cnt_nxt;
  logic [F_W-1:0]     r_flush_cnt, w_flush_cnt_nxt;
  logic               w_free, w_in_ready, w_accept;
  logic               w_load, w_shift;
  logic [DATA_W-1:0]  w_din, w_fill, w_pad;

`ifdef PIXEL_WINDOW_REPLICATE_EN
  logic [DATA_W-1:0]  r_last;

  // Last accepted pixel, replayed as padding during the flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= '0;
    end else if (w_accept) begin
      r_last <= in_pixel;
    end
  end

  assign w_pad  = r_last;
  assign w_fill = in_pixel;
`else
  assign w_pad  = '0;
  assign w_fill = '0;
`endif

  assign w_free     = !r_valid || out_ready;
  assign w_in_ready = !rst && w_free && (r_state != FLUSH);
  assign w_accept   = in_valid && w_in_ready;
  assign in_ready   = w_in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_valid_nxt     = r_valid;
    w_in_cnt_nxt    = r_in_cnt;
    w_flush_cnt_nxt = r_flush_cnt;
    w_load          = 1'b0;
    w_shift         = 1'b0;
    w_din           = in_pixel;
    w_x_nxt         = r_x;
    w_eol_nxt       = 1'b0;

    // Everything advances only when the output slot is free; otherwise hold.
    if (w_free) begin
      w_valid_nxt = 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            w_load       = 1'b1;
            w_in_cnt_nxt = X_W'(1);
            w_state_nxt  = RUN;
          end
        end
        RUN: begin
          if (w_accept) begin
            w_shift     = 1'b1;
            w_valid_nxt = (r_in_cnt >= X_W'(H));
            if (r_in_cnt == X_W'(LINE_W - 1)) begin
              w_in_cnt_nxt    = '0;
              w_flush_cnt_nxt = '0;
              w_state_nxt     = FLUSH;
            end else begin
              w_in_cnt_nxt = r_in_cnt + X_W'(1);
            end
          end
        end
        FLUSH: begin
          w_shift     = 1'b1;
          w_din       = w_pad;
          w_valid_nxt = 1'b1;
          if (r_flush_cnt == F_W'(H - 1)) begin
            w_flush_cnt_nxt = '0;
            w_state_nxt     = IDLE;
          end else begin
            w_flush_cnt_nxt = r_flush_cnt + F_W'(1);
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end

    if (r_valid && out_ready) begin
      w_x_nxt = (r_x == X_W'(LINE_W - 1)) ? '0 : r_x + X_W'(1);
    end
    w_eol_nxt = w_valid_nxt && (w_x_nxt == X_W'(LINE_W - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_eol       <= 1'b0;
      r_x         <= '0;
      r_in_cnt    <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_valid     <= w_valid_nxt;
      r_eol       <= w_eol_nxt;
      r_x         <= w_x_nxt;
      r_in_cnt    <= w_in_cnt_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  window_shift_reg #(
    .DATA_W (DATA_W),
    .TAPS   (TAPS)
  ) u_window (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_shift  (w_shift),
    .i_din    (w_din),
    .i_fill   (w_fill),
    .o_window (out_window)
  );

  assign out_valid = r_valid;
  assign out_x     = r_x;
  assign out_eol   = r_eol;

endmodule
